led_sequencer: RTL

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer_pkg.sv | 28 ++
 rtl/led_tick_gen.sv | 35 +++
 rtl/led_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/led_sequencer_pkg.sv
// Shared encodings for the LED sequencer: LED width, mode codes, FSM states
// and the per-mode start pattern.
package led_sequencer_pkg;

    localparam int unsigned LED_W = 5;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF   = 2'd0;
    localparam mode_t MODE_SCAN  = 2'd1;
    localparam mode_t MODE_COUNT = 2'd2;
    localparam mode_t MODE_BLINK = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    function automatic logic [LED_W-1:0] mode_start(input mode_t mode);
        logic [LED_W-1:0] val;
        unique case (mode)
            MODE_SCAN:  val = LED_W'(1);
            MODE_BLINK: val = '1;
            default:    val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..DIV-1 and pulses tick on the last count.
// clr restarts the count from 0 and takes priority over the wrap.
module led_tick_gen #(
    parameter int unsigned DIV = 25000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("led_tick_gen: DIV must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// Five-LED pattern sequencer with a level request / one-cycle ack mode handshake.
// rstn deassertion is assumed already synchronised to clk by the integrating top level.
module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter int unsigned DIV = 25000000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             mode_req,
    input  logic [1:0]       mode_sel,
    output logic             mode_ack,
    output logic [1:0]       mode_cur,
    output logic [LED_W-1:0] led
);

    logic [1:0]       state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             ack_q, ack_d;
    logic             scan_right_q, scan_right_d;
    logic             armed_q, armed_d;
    logic             accept;
    logic             tick;

    led_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rstn (rstn),
        .clr  (accept),
        .tick (tick)
    );

    // A held request is accepted once; it must be seen low before re-arming.
    assign accept = mode_req && armed_q && (state_q != ST_ACK);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        led_d        = led_q;
        scan_right_d = scan_right_q;
        ack_d        = accept;
        armed_d      = armed_q;

        if (accept) begin
            armed_d = 1'b0;
        end else if (!mode_req) begin
            armed_d = 1'b1;
        end

        if (accept) begin
            state_d      = ST_ACK;
            mode_d       = mode_sel;
            led_d        = mode_start(mode_sel);
            scan_right_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    led_d = '0;
                end
                ST_ACK: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (tick) begin
                        unique case (mode_q)
                            MODE_OFF: led_d = '0;
                            // Bounce without repeating the end LED: reverse and step inward.
                            MODE_SCAN: begin
                                if (!scan_right_q) begin
                                    if (led_q[LED_W-1]) begin
                                        led_d        = led_q >> 1;
                                        scan_right_d = 1'b1;
                                    end else begin
                                        led_d = led_q << 1;
                                    end
                                end else begin
                                    if (led_q[0]) begin
                                        led_d        = led_q << 1;
                                        scan_right_d = 1'b0;
                                    end else begin
                                        led_d = led_q >> 1;
                                    end
                                end
                            end
                            MODE_COUNT: led_d = led_q + LED_W'(1);
                            MODE_BLINK: led_d = ~led_q;
                            default:    led_d = '0;
                        endcase
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    led_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_OFF;
            led_q        <= '0;
            ack_q        <= 1'b0;
            scan_right_q <= 1'b0;
            armed_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            led_q        <= led_d;
            ack_q        <= ack_d;
            scan_right_q <= scan_right_d;
            armed_q      <= armed_d;
        end
    end

    assign mode_ack = ack_q;
    assign mode_cur = mode_q;
    assign led      = led_q;

endmodule
